pipeline_run_ctrl: RTL

//  Run/step/halt sequencer for the 5-stage MIPS pipeline. Generates the global pipeline enable and the PC enable.

---
 rtl/mips_ctrl_pkg.sv | 25 ++
 rtl/pipeline_run_ctrl_sat_counter.sv | 43 ++++
 rtl/pipeline_run_ctrl.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/mips_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// mips_ctrl_pkg
//   Shared definitions for the MIPS pipeline control blocks: the run
//   sequencer state encoding and the NOP instruction word used for bubbles.
// ---------------------------------------------------------------------------
package mips_ctrl_pkg;

    // Run sequencer states (3-bit encoding)
    localparam logic [2:0] ST_IDLE      = 3'd0;
    localparam logic [2:0] ST_RUN       = 3'd1;
    localparam logic [2:0] ST_STEP_WAIT = 3'd2;
    localparam logic [2:0] ST_STEP_GO   = 3'd3;
    localparam logic [2:0] ST_DRAIN     = 3'd4;
    localparam logic [2:0] ST_DONE      = 3'd5;

    // sll $0,$0,0 - the canonical MIPS NOP, injected into IF/ID while draining
    localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

    // True in the states where the sequencer owns the pipeline
    function automatic logic state_is_busy(input logic [2:0] st);
        return (st == ST_RUN) || (st == ST_STEP_WAIT) ||
               (st == ST_STEP_GO) || (st == ST_DRAIN);
    endfunction

endpackage

// File: rtl/pipeline_run_ctrl_sat_counter.sv
// ---------------------------------------------------------------------------
// sat_counter
//   Up-counter that sticks at its all-ones value instead of wrapping.
//   Ports:
//     clk     in   clock, rising edge
//     reset   in   synchronous, active-low
//     clr_i   in   clear to zero (has priority over inc_i)
//     inc_i   in   increment by one unless saturated
//     q_o     out  WIDTH-bit count
// ---------------------------------------------------------------------------
module sat_counter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clr_i,
    input  logic             inc_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] q_q;
    logic [WIDTH-1:0] q_d;

    always_comb begin
        q_d = q_q;
        if (clr_i) begin
            q_d = '0;
        end else if (inc_i && (q_q != {WIDTH{1'b1}})) begin
            q_d = q_q + WIDTH'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            q_q <= '0;
        end else begin
            q_q <= q_d;
        end
    end

    assign q_o = q_q;

endmodule

// File: rtl/pipeline_run_ctrl.sv
// ---------------------------------------------------------------------------
// pipeline_run_ctrl
//   Run/step/halt sequencer for the 5-stage MIPS pipeline. Produces the
//   global pipeline enable and the PC/IF-ID enable, drains older
//   instructions once a HALT is accepted in ID, and counts enabled cycles.
//   All outputs are Moore (decoded from registered state).
//
//   Handshake: start and step_req are single-cycle request pulses with no
//   ready return; a pulse is consumed on the rising edge where the FSM is in
//   a state that accepts it and is silently dropped otherwise.
//
//   Ports:
//     clk           in   clock, rising edge
//     reset         in   synchronous, active-low
//     start         in   begin execution (IDLE/DONE only)
//     step_mode     in   sampled with start: 1 = single-step
//     step_req      in   advance one cycle (step mode only)
//     halt_id       in   HALT decoded in ID
//     hazard_stall  in   ID stall from hazard unit
//     pipe_en       out  enable for pipeline registers / RF write
//     fetch_en      out  PC and IF/ID enable
//     bubble_id     out  force IF/ID to NOP while draining
//     busy          out  RUN, STEP_WAIT, STEP_GO or DRAIN
//     done          out  DONE (sticky until start or reset)
//     cycle_count   out  enabled cycles since last start (saturating)
//     dbg_state     out  current FSM state
// ---------------------------------------------------------------------------
module pipeline_run_ctrl
    import mips_ctrl_pkg::*;
#(
    parameter int CNT_W        = 32,
    parameter int DRAIN_CYCLES = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             step_mode,
    input  logic             step_req,
    input  logic             halt_id,
    input  logic             hazard_stall,
    output logic             pipe_en,
    output logic             fetch_en,
    output logic             bubble_id,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] cycle_count,
    output logic [2:0]       dbg_state
);

    localparam int DW = $clog2(DRAIN_CYCLES + 1);

    logic [2:0]    state_q, state_d;
    logic [DW-1:0] drain_cnt_q, drain_cnt_d;
    logic          step_mode_q, step_mode_d;
    // In step-mode drain, one enabled cycle follows each step_req
    logic          drain_go_q, drain_go_d;
    logic          start_acc;
    logic          halt_acc;

    assign start_acc = start && ((state_q == ST_IDLE) || (state_q == ST_DONE));
    assign halt_acc  = halt_id && !hazard_stall;

    // Moore outputs
    always_comb begin
        pipe_en   = 1'b0;
        fetch_en  = 1'b0;
        bubble_id = 1'b0;
        case (state_q)
            ST_RUN, ST_STEP_GO: begin
                pipe_en  = 1'b1;
                fetch_en = 1'b1;
            end
            ST_DRAIN: begin
                pipe_en   = !step_mode_q || drain_go_q;
                bubble_id = 1'b1;
            end
            default: ;
        endcase
    end

    assign busy      = state_is_busy(state_q);
    assign done      = (state_q == ST_DONE);
    assign dbg_state = state_q;

    // Next state
    always_comb begin
        state_d     = state_q;
        drain_cnt_d = drain_cnt_q;
        step_mode_d = step_mode_q;
        drain_go_d  = 1'b0;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    step_mode_d = step_mode;
                    state_d     = step_mode ? ST_STEP_WAIT : ST_RUN;
                end
            end
            ST_RUN: begin
                if (halt_acc) begin
                    state_d     = ST_DRAIN;
                    drain_cnt_d = DW'(DRAIN_CYCLES);
                end
            end
            ST_STEP_WAIT: begin
                if (step_req) state_d = ST_STEP_GO;
            end
            ST_STEP_GO: begin
                if (halt_acc) begin
                    state_d     = ST_DRAIN;
                    drain_cnt_d = DW'(DRAIN_CYCLES);
                end else begin
                    state_d = ST_STEP_WAIT;
                end
            end
            ST_DRAIN: begin
                drain_go_d = step_mode_q && step_req;
                if (pipe_en) begin
                    drain_cnt_d = drain_cnt_q - DW'(1);
                    if (drain_cnt_q == DW'(1)) begin
                        state_d    = ST_DONE;
                        drain_go_d = 1'b0;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            drain_cnt_q <= '0;
            step_mode_q <= 1'b0;
            drain_go_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            drain_cnt_q <= drain_cnt_d;
            step_mode_q <= step_mode_d;
            drain_go_q  <= drain_go_d;
        end
    end

    sat_counter #(.WIDTH(CNT_W)) u_cycle_cnt (
        .clk   (clk),
        .reset (reset),
        .clr_i (start_acc),
        .inc_i (pipe_en),
        .q_o   (cycle_count)
    );

endmodule
